// File: rtl/arith_cmpf_pipe.sv
// arith_cmpf_pipe: two-stage pipelined IEEE-754 comparator with a runtime
// predicate, valid/ready handshaking and sticky signaling-NaN reporting.
module arith_cmpf_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_pred,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic             out_invalid,
  input  logic             clear_status,
  output logic             status_invalid
);

  localparam int unsigned MAG_W = EXP_W + MAN_W;

  typedef enum logic [3:0] {
    PRED_FALSE = 4'd0,
    PRED_OEQ   = 4'd1,
    PRED_OGT   = 4'd2,
    PRED_OGE   = 4'd3,
    PRED_OLT   = 4'd4,
    PRED_OLE   = 4'd5,
    PRED_ONE   = 4'd6,
    PRED_ORD   = 4'd7,
    PRED_UEQ   = 4'd8,
    PRED_UGT   = 4'd9,
    PRED_UGE   = 4'd10,
    PRED_ULT   = 4'd11,
    PRED_ULE   = 4'd12,
    PRED_UNE   = 4'd13,
    PRED_UNO   = 4'd14,
    PRED_TRUE  = 4'd15
  } pred_t;

  // Parameter sanity at elaboration.
  if (EXP_W < 2) begin : g_bad_exp_w
    $fatal(1, "arith_cmpf_pipe: EXP_W must be >= 2");
  end
  if (MAN_W < 1) begin : g_bad_man_w
    $fatal(1, "arith_cmpf_pipe: MAN_W must be >= 1");
  end

  // Field split of both operands.
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic [MAG_W-1:0] mag_a, mag_b;

  assign sign_a = in_a[WIDTH-1];
  assign sign_b = in_b[WIDTH-1];
  assign exp_a  = in_a[MAG_W-1:MAN_W];
  assign exp_b  = in_b[MAG_W-1:MAN_W];
  assign man_a  = in_a[MAN_W-1:0];
  assign man_b  = in_b[MAN_W-1:0];
  assign mag_a  = in_a[MAG_W-1:0];
  assign mag_b  = in_b[MAG_W-1:0];

  // Pipeline state.
  logic  s1_valid, s2_valid;
  logic  s1_unord, s1_snan, s1_eq, s1_lt;
  pred_t s1_pred;
  logic  s1_adv, s2_adv;

  // Classification and ordering of the incoming operands.
  logic nan_a, nan_b, snan_a, snan_b, zero_a, zero_b;
  logic unord_c, snan_c, eq_c, lt_c;

  always_comb begin
    nan_a   = (&exp_a) && (|man_a);
    nan_b   = (&exp_b) && (|man_b);
    snan_a  = nan_a && !man_a[MAN_W-1];
    snan_b  = nan_b && !man_b[MAN_W-1];
    zero_a  = ~|mag_a;
    zero_b  = ~|mag_b;
    unord_c = nan_a || nan_b;
    snan_c  = snan_a || snan_b;
    eq_c    = (zero_a && zero_b) || (in_a == in_b);
    lt_c    = 1'b0;
    if (zero_a && zero_b) begin
      lt_c = 1'b0;
    end else if (sign_a != sign_b) begin
      lt_c = sign_a;
    end else if (!sign_a) begin
      lt_c = (mag_a < mag_b);
    end else begin
      lt_c = (mag_a > mag_b);
    end
  end

  // Handshake: a stage moves when its successor can take the data.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Predicate evaluation on the S1 classification.
  logic gt_c, result_c;

  always_comb begin
    gt_c     = !s1_eq && !s1_lt;
    result_c = 1'b0;
    case (s1_pred)
      PRED_FALSE: result_c = 1'b0;
      PRED_OEQ:   result_c = !s1_unord && s1_eq;
      PRED_OGT:   result_c = !s1_unord && gt_c;
      PRED_OGE:   result_c = !s1_unord && (gt_c || s1_eq);
      PRED_OLT:   result_c = !s1_unord && s1_lt;
      PRED_OLE:   result_c = !s1_unord && (s1_lt || s1_eq);
      PRED_ONE:   result_c = !s1_unord && !s1_eq;
      PRED_ORD:   result_c = !s1_unord;
      PRED_UEQ:   result_c = s1_unord || s1_eq;
      PRED_UGT:   result_c = s1_unord || gt_c;
      PRED_UGE:   result_c = s1_unord || gt_c || s1_eq;
      PRED_ULT:   result_c = s1_unord || s1_lt;
      PRED_ULE:   result_c = s1_unord || s1_lt || s1_eq;
      PRED_UNE:   result_c = s1_unord || !s1_eq;
      PRED_UNO:   result_c = s1_unord;
      PRED_TRUE:  result_c = 1'b1;
      default:    result_c = 1'b0;
    endcase
  end

  // Stage valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end

  // S1 payload: classification captured together with the predicate.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_unord <= unord_c;
      s1_snan  <= snan_c;
      s1_eq    <= eq_c;
      s1_lt    <= lt_c;
      s1_pred  <= pred_t'(in_pred);
    end
  end

  // S2 payload: final result, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result  <= 1'b0;
      out_invalid <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      out_result  <= result_c;
      out_invalid <= s1_snan;
    end
  end

  assign out_valid = s2_valid;

  // Sticky invalid flag; a delivered sNaN result beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_invalid <= 1'b0;
    end else if (s2_valid && out_ready && out_invalid) begin
      status_invalid <= 1'b1;
    end else if (clear_status) begin
      status_invalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arith_cmpf_pipe.sv
// tb_arith_cmpf_pipe: randomized and directed checks of arith_cmpf_pipe at
// f32 and f16 against a value-based reference model.
module tb_arith_cmpf_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // f32 instance signals
  logic        iv32 = 0, ir32, ov32, or32 = 0, res32, inv32, clr32 = 0, st32;
  logic [31:0] a32 = 0, b32 = 0;
  logic [3:0]  p32 = 0;

  // f16 instance signals
  logic        iv16 = 0, ir16, ov16, or16 = 0, res16, inv16, st16;
  logic        clr16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic [3:0]  p16 = 0;

  arith_cmpf_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_a(a32), .in_b(b32),
    .in_pred(p32), .out_valid(ov32), .out_ready(or32), .out_result(res32),
    .out_invalid(inv32), .clear_status(clr32), .status_invalid(st32));

  arith_cmpf_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_pred(p16), .out_valid(ov16), .out_ready(or16), .out_result(res16),
    .out_invalid(inv16), .clear_status(clr16), .status_invalid(st16));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: map each non-NaN value onto a signed integer key whose order
  // equals numeric order (both zeros map to 0), then apply the predicate.
  function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] p, input int ew, input int mw);
    longint ua, ub, ea, eb, ma, mb, emax, ka, kb;
    logic   na, nb, sa, sb, un, eq, lt, gt, r, inv;
    ua = longint'(a); ub = longint'(b);
    emax = (64'd1 << ew) - 1;
    ma = ua & ((64'd1 << mw) - 1);   mb = ub & ((64'd1 << mw) - 1);
    ea = (ua >> mw) & emax;          eb = (ub >> mw) & emax;
    sa = ((ua >> (ew + mw)) & 1) != 0;
    sb = ((ub >> (ew + mw)) & 1) != 0;
    na = (ea == emax) && (ma != 0);
    nb = (eb == emax) && (mb != 0);
    inv = (na && ((ma >> (mw - 1)) & 1) == 0) || (nb && ((mb >> (mw - 1)) & 1) == 0);
    ka = (ea << mw) | ma;  if (sa) ka = -ka;
    kb = (eb << mw) | mb;  if (sb) kb = -kb;
    un = na || nb;
    eq = (ka == kb); lt = (ka < kb); gt = (ka > kb);
    case (p)
      4'd0:  r = 0;
      4'd1:  r = !un && eq;
      4'd2:  r = !un && gt;
      4'd3:  r = !un && (gt || eq);
      4'd4:  r = !un && lt;
      4'd5:  r = !un && (lt || eq);
      4'd6:  r = !un && !eq;
      4'd7:  r = !un;
      4'd8:  r = un || eq;
      4'd9:  r = un || gt;
      4'd10: r = un || gt || eq;
      4'd11: r = un || lt;
      4'd12: r = un || lt || eq;
      4'd13: r = un || !eq;
      4'd14: r = un;
      default: r = 1;
    endcase
    return {r, inv};
  endfunction

  // f32 scoreboard, hold-stability and sticky-status monitor.
  logic [1:0] sb32[$];
  logic       st_exp = 0, prev_stall = 0, prev_res = 0, prev_inv = 0;
  int         n_out32 = 0;

  always @(negedge clk) begin
    logic [1:0] e;
    logic       hs_inv;
    if (rst) begin
      sb32.delete();
      st_exp = 0;
      prev_stall = 0;
    end else begin
      chk("status32", 32'(st32), 32'(st_exp));
      if (prev_stall) begin
        chk("hold_valid", 32'(ov32), 1);
        chk("hold_result", 32'(res32), 32'(prev_res));
        chk("hold_invalid", 32'(inv32), 32'(prev_inv));
      end
      prev_stall = ov32 && !or32;
      prev_res = res32;
      prev_inv = inv32;
      if (iv32 && ir32) sb32.push_back(ref_cmp(a32, b32, p32, 8, 23));
      hs_inv = 0;
      if (ov32 && or32) begin
        chk("sb_nonempty", 32'(sb32.size() != 0), 1);
        if (sb32.size() != 0) begin
          e = sb32.pop_front();
          chk("sb_result", 32'(res32), 32'(e[1]));
          chk("sb_invalid", 32'(inv32), 32'(e[0]));
          hs_inv = e[0];
          n_out32++;
        end
      end
      st_exp = hs_inv ? 1'b1 : (clr32 ? 1'b0 : st_exp);
    end
  end

  // One isolated f32 transaction with explicit two-cycle latency checks.
  task automatic send32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] p, input logic er, input logic ei, input logic clr);
    @(posedge clk); #1;
    iv32 = 1; a32 = a; b32 = b; p32 = p; or32 = 1; clr32 = 0;
    @(negedge clk);
    chk({tag, "_accept"}, 32'(ir32), 1);
    @(posedge clk); #1;
    iv32 = 0;
    @(negedge clk);
    chk({tag, "_early"}, 32'(ov32), 0);
    @(posedge clk); #1;
    clr32 = clr;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(ov32), 1);
    chk({tag, "_result"}, 32'(res32), 32'(er));
    chk({tag, "_invalid"}, 32'(inv32), 32'(ei));
  endtask

  task automatic send16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] p, input logic er, input logic ei);
    @(posedge clk); #1;
    iv16 = 1; a16 = a; b16 = b; p16 = p; or16 = 1;
    @(negedge clk);
    chk({tag, "_accept"}, 32'(ir16), 1);
    @(posedge clk); #1;
    iv16 = 0;
    @(negedge clk);
    chk({tag, "_early"}, 32'(ov16), 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(ov16), 1);
    chk({tag, "_result"}, 32'(res16), 32'(er));
    chk({tag, "_invalid"}, 32'(inv16), 32'(ei));
  endtask

  function automatic logic [31:0] pick32();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7F80_0000;
      3: return 32'hFF80_0000;
      4: return {r[31], 9'h1FF, r[21:0]};
      5: return {r[31], 9'h0FF, 1'b0, r[21:1], 1'b1};
      6: return {r[31], 8'h00, r[22:0]};
      default: return r;
    endcase
  endfunction

  function automatic logic [15:0] pick16();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return {r[15], 5'h1F, 10'h000};
      3: return {r[15], 5'h1F, r[9:0] | 10'h001};
      4: return {r[15], 5'h00, r[9:0]};
      default: return r;
    endcase
  endfunction

  logic [31:0] bp_a[4] = '{32'h3F80_0000, 32'h7FC0_0000, 32'hBF80_0000, 32'h7F80_0001};
  logic [31:0] bp_b[4] = '{32'h4000_0000, 32'h3F80_0000, 32'hC000_0000, 32'h3F80_0000};
  logic [3:0]  bp_p[4] = '{4'd4, 4'd13, 4'd2, 4'd15};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  e;
    logic [31:0] ra, rb;
    logic [15:0] ha, hb;
    logic [3:0]  rp;
    int          idx, base;

    // Reset values
    #3;
    chk("rst_out_valid", 32'(ov32), 0);
    chk("rst_out_result", 32'(res32), 0);
    chk("rst_out_invalid", 32'(inv32), 0);
    chk("rst_status", 32'(st32), 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_after_rst", 32'(ir32), 1);

    // Directed f32 cases
    send32("olt_1_2", 32'h3F80_0000, 32'h4000_0000, 4'd4, 1, 0, 0);
    send32("ogt_1_2", 32'h3F80_0000, 32'h4000_0000, 4'd2, 0, 0, 0);
    send32("qnan_une", 32'h7FC0_0000, 32'h3F80_0000, 4'd13, 1, 0, 0);
    send32("qnan_oeq", 32'h7FC0_0000, 32'h3F80_0000, 4'd1, 0, 0, 0);
    send32("qnan_uno", 32'h7FC0_0000, 32'h3F80_0000, 4'd14, 1, 0, 0);
    send32("qnan_ord", 32'h7FC0_0000, 32'h3F80_0000, 4'd7, 0, 0, 0);
    send32("zero_oeq", 32'h8000_0000, 32'h0000_0000, 4'd1, 1, 0, 0);
    send32("neg_ogt", 32'hBF80_0000, 32'hC000_0000, 4'd2, 1, 0, 0);
    send32("subn_olt", 32'h0000_0001, 32'h0000_0002, 4'd4, 1, 0, 0);

    // Sticky status: set, set-with-clear, then clear alone
    send32("snan_true", 32'h7F80_0001, 32'h3F80_0000, 4'd15, 1, 1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("status_set", 32'(st32), 1);
    send32("snan_false", 32'h3F80_0000, 32'hFF80_0005, 4'd0, 0, 1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("status_set_wins", 32'(st32), 1);
    @(posedge clk); #1;
    clr32 = 0;
    @(negedge clk);
    chk("status_cleared", 32'(st32), 0);

    // Backpressure: four offered, two accepted while stalled
    base = n_out32;
    idx = 0;
    @(posedge clk); #1;
    or32 = 0;
    repeat (6) begin
      iv32 = (idx < 4);
      if (idx < 4) begin a32 = bp_a[idx]; b32 = bp_b[idx]; p32 = bp_p[idx]; end
      @(negedge clk);
      if (iv32 && ir32) idx++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", 32'(idx), 2);
    chk("bp_ready_low", 32'(ir32), 0);
    chk("bp_no_output_yet", 32'(n_out32 - base), 0);
    or32 = 1;
    for (int k = 0; k < 20 && idx < 4; k++) begin
      iv32 = 1; a32 = bp_a[idx]; b32 = bp_b[idx]; p32 = bp_p[idx];
      @(negedge clk);
      if (ir32) idx++;
      @(posedge clk); #1;
    end
    iv32 = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_all_out", 32'(n_out32 - base), 4);

    // Randomized f32 traffic with random backpressure and clears
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      ra = pick32();
      case ($urandom_range(0, 5))
        0: rb = ra;
        1: rb = {~ra[31], ra[30:0]};
        default: rb = pick32();
      endcase
      iv32 = ($urandom_range(0, 3) != 0);
      a32 = ra; b32 = rb; p32 = 4'($urandom);
      or32 = ($urandom_range(0, 9) < 7);
      clr32 = ($urandom_range(0, 15) == 0);
    end
    @(posedge clk); #1;
    iv32 = 0; or32 = 1; clr32 = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb32.size()), 0);

    // f16 directed and random
    send16("f16_ogt", 16'h3C00, 16'hBC00, 4'd2, 1, 0);
    for (int i = 0; i < 40; i++) begin
      ha = pick16();
      hb = ($urandom_range(0, 4) == 0) ? ha : pick16();
      rp = 4'($urandom);
      e = ref_cmp({16'h0, ha}, {16'h0, hb}, rp, 5, 10);
      send16("f16_rand", ha, hb, rp, e[1], e[0]);
    end

    // Asynchronous reset with two f16 transactions in flight
    @(posedge clk); #1;
    iv16 = 1; a16 = 16'h3C00; b16 = 16'hBC00; p16 = 4'd2; or16 = 1;
    @(posedge clk); #1;
    a16 = 16'h3C00; b16 = 16'h3C00; p16 = 4'd1;
    @(posedge clk); #1;
    iv16 = 0;
    chk("f16_inflight", 32'(ov16), 1);
    rst = 1;
    #1;
    chk("f16_rst_valid", 32'(ov16), 0);
    chk("f16_rst_result", 32'(res16), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("f16_ready_after_rst", 32'(ir16), 1);
    repeat (4) begin
      @(negedge clk);
      chk("f16_no_stale", 32'(ov16), 0);
    end
    send16("f16_post_rst", 16'hBC00, 16'h3C00, 4'd4, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
